// File: rtl/fiu_mem_if.sv
// CCI-P style memory channel bundle between an initiator and the FIU responder.
// Tx carries line requests and almfull backpressure, and Rx carries responses.
interface fiu_mem_if #(
  parameter int ADDR_W  = 42,
  parameter int MDATA_W = 16
);
  logic               c0tx_valid;
  logic [ADDR_W-1:0]  c0tx_addr;
  logic [MDATA_W-1:0] c0tx_mdata;
  logic               c0tx_almfull;
  logic               c1tx_valid;
  logic [ADDR_W-1:0]  c1tx_addr;
  logic [MDATA_W-1:0] c1tx_mdata;
  logic [511:0]       c1tx_data;
  logic               c1tx_almfull;
  logic               c0rx_rsp_valid;
  logic [MDATA_W-1:0] c0rx_mdata;
  logic [511:0]       c0rx_data;
  logic               c1rx_rsp_valid;
  logic [MDATA_W-1:0] c1rx_mdata;

  modport master (
    output c0tx_valid, c0tx_addr, c0tx_mdata,
    output c1tx_valid, c1tx_addr, c1tx_mdata, c1tx_data,
    input  c0tx_almfull, c1tx_almfull,
    input  c0rx_rsp_valid, c0rx_mdata, c0rx_data,
    input  c1rx_rsp_valid, c1rx_mdata
  );

  modport slave (
    input  c0tx_valid, c0tx_addr, c0tx_mdata,
    input  c1tx_valid, c1tx_addr, c1tx_mdata, c1tx_data,
    output c0tx_almfull, c1tx_almfull,
    output c0rx_rsp_valid, c0rx_mdata, c0rx_data,
    output c1rx_rsp_valid, c1rx_mdata
  );
endinterface

// File: rtl/fiu_mem_responder.sv
// FIU-side memory channel model: in-order request queues, fixed-latency
// service against a small line store, read data and write acks.
module fiu_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int SLACK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         almfull,
  output logic         overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] THR_CNT  = (AW+1)'(DEPTH - SLACK);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          almfull_q, almfull_d;
  logic          ovf_q, ovf_d;
  logic          do_push, do_pop;

  // A pop on the same edge frees the slot, so a full queue still accepts.
  always_comb begin
    do_pop    = pop && (cnt_q != '0);
    do_push   = push && ((cnt_q != FULL_CNT) || do_pop);
    wp_d      = wp_q + AW'(do_push);
    rp_d      = rp_q + AW'(do_pop);
    cnt_d     = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    almfull_d = (cnt_q >= THR_CNT);
    ovf_d     = ovf_q | (push & ~do_push);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      almfull_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      almfull_q <= almfull_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= din;
  end

  assign dout     = mem_q[rp_q];
  assign empty    = (cnt_q == '0);
  assign almfull  = almfull_q;
  assign overflow = ovf_q;
endmodule

module fiu_mem_responder #(
  parameter int ADDR_W        = 42,
  parameter int MDATA_W       = 16,
  parameter int LINES_LOG2    = 6,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 2,
  parameter int LATENCY       = 20
) (
  input  logic        clk,
  input  logic        reset,
  fiu_mem_if.slave    bus,
  output logic [15:0] rd_served_cnt,
  output logic [15:0] wr_served_cnt,
  output logic        overflow
);
  localparam int LINES = 1 << LINES_LOG2;
  localparam logic [15:0] LAT_M1 = 16'(LATENCY - 1);

  typedef logic [LINES_LOG2-1:0] idx_t;

  typedef struct packed {
    logic [15:0]        stamp;
    logic [MDATA_W-1:0] mdata;
    idx_t               idx;
  } rd_ent_t;

  typedef struct packed {
    logic [15:0]        stamp;
    logic [MDATA_W-1:0] mdata;
    idx_t               idx;
    logic [511:0]       data;
  } wr_ent_t;

  logic [15:0]        cyc_q, cyc_d;
  rd_ent_t            rd_in, rd_head;
  wr_ent_t            wr_in, wr_head;
  logic               rd_empty, wr_empty;
  logic               rd_go, wr_go;
  logic               rd_ovf, wr_ovf;
  logic               rd_almfull, wr_almfull;
  logic [15:0]        rd_age, wr_age;
  logic [511:0]       line_q [LINES];
  logic [LINES-1:0]   written_q, written_d;
  logic               c0_vld_q, c0_vld_d;
  logic [MDATA_W-1:0] c0_mdata_q, c0_mdata_d;
  logic [511:0]       c0_data_q, c0_data_d;
  logic               c1_vld_q, c1_vld_d;
  logic [MDATA_W-1:0] c1_mdata_q, c1_mdata_d;
  logic [15:0]        rd_cnt_q, rd_cnt_d;
  logic [15:0]        wr_cnt_q, wr_cnt_d;
  logic               unused_addr_hi;

  // Only the low address bits index the store; upper bits alias.
  assign unused_addr_hi = ^{bus.c0tx_addr[ADDR_W-1:LINES_LOG2],
                            bus.c1tx_addr[ADDR_W-1:LINES_LOG2]};

  always_comb begin
    rd_in       = '0;
    rd_in.stamp = cyc_q;
    rd_in.mdata = bus.c0tx_mdata;
    rd_in.idx   = bus.c0tx_addr[LINES_LOG2-1:0];
    wr_in       = '0;
    wr_in.stamp = cyc_q;
    wr_in.mdata = bus.c1tx_mdata;
    wr_in.idx   = bus.c1tx_addr[LINES_LOG2-1:0];
    wr_in.data  = bus.c1tx_data;
  end

  fiu_req_fifo #(
    .W($bits(rd_ent_t)), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)
  ) u_rd_q (
    .clk(clk), .rst(reset),
    .push(bus.c0tx_valid), .din(rd_in),
    .pop(rd_go), .dout(rd_head),
    .empty(rd_empty), .almfull(rd_almfull), .overflow(rd_ovf)
  );

  fiu_req_fifo #(
    .W($bits(wr_ent_t)), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)
  ) u_wr_q (
    .clk(clk), .rst(reset),
    .push(bus.c1tx_valid), .din(wr_in),
    .pop(wr_go), .dout(wr_head),
    .empty(wr_empty), .almfull(wr_almfull), .overflow(wr_ovf)
  );

  // Age compare is mod 2^16, so a late head is serviced as soon as it surfaces.
  always_comb begin
    rd_age = cyc_q - rd_head.stamp;
    wr_age = cyc_q - wr_head.stamp;
    rd_go  = !rd_empty && (rd_age >= LAT_M1);
    wr_go  = !wr_empty && (wr_age >= LAT_M1);
  end

  always_comb begin
    cyc_d      = cyc_q + 16'd1;
    c0_vld_d   = rd_go;
    c0_mdata_d = c0_mdata_q;
    c0_data_d  = c0_data_q;
    rd_cnt_d   = rd_cnt_q;
    c1_vld_d   = wr_go;
    c1_mdata_d = c1_mdata_q;
    wr_cnt_d   = wr_cnt_q;
    written_d  = written_q;
    if (rd_go) begin
      c0_mdata_d = rd_head.mdata;
      c0_data_d  = written_q[rd_head.idx] ? line_q[rd_head.idx] : '0;
      rd_cnt_d   = rd_cnt_q + 16'd1;
    end
    if (wr_go) begin
      c1_mdata_d                = wr_head.mdata;
      wr_cnt_d                  = wr_cnt_q + 16'd1;
      written_d[wr_head.idx]    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q      <= '0;
      written_q  <= '0;
      c0_vld_q   <= 1'b0;
      c0_mdata_q <= '0;
      c0_data_q  <= '0;
      c1_vld_q   <= 1'b0;
      c1_mdata_q <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      cyc_q      <= cyc_d;
      written_q  <= written_d;
      c0_vld_q   <= c0_vld_d;
      c0_mdata_q <= c0_mdata_d;
      c0_data_q  <= c0_data_d;
      c1_vld_q   <= c1_vld_d;
      c1_mdata_q <= c1_mdata_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Store contents survive reset; the written bits gate stale data instead.
  always_ff @(posedge clk) begin
    if (wr_go) line_q[wr_head.idx] <= wr_head.data;
  end

  assign bus.c0tx_almfull   = rd_almfull;
  assign bus.c1tx_almfull   = wr_almfull;
  assign bus.c0rx_rsp_valid = c0_vld_q;
  assign bus.c0rx_mdata     = c0_mdata_q;
  assign bus.c0rx_data      = c0_data_q;
  assign bus.c1rx_rsp_valid = c1_vld_q;
  assign bus.c1rx_mdata     = c1_mdata_q;
  assign rd_served_cnt      = rd_cnt_q;
  assign wr_served_cnt      = wr_cnt_q;
  assign overflow           = rd_ovf | wr_ovf;
endmodule

// File: tb/tb_fiu_mem_responder.sv
// Directed bench for fiu_mem_responder: latency, data, backpressure,
// hazards, mid-flight reset and counter wrap.
module tb_fiu_mem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
  logic        ovf0, ovf1;
  int          vectors = 0;
  int          miscompares = 0;

  localparam logic [511:0] DAT_A = {448'h0, 64'hA8899ABB_CCDDEEFF};
  localparam logic [511:0] PAT_AA = {64{8'hAA}};
  localparam logic [511:0] PAT_BB = {64{8'hBB}};

  fiu_mem_if #(.ADDR_W(42), .MDATA_W(16)) bus0();
  fiu_mem_if #(.ADDR_W(42), .MDATA_W(16)) bus1();

  fiu_mem_responder #(.LATENCY(20)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0),
    .rd_served_cnt(rd_cnt0), .wr_served_cnt(wr_cnt0),
    .overflow(ovf0)
  );

  fiu_mem_responder #(.LATENCY(2)) u_wrap (
    .clk(clk), .reset(reset), .bus(bus1),
    .rd_served_cnt(rd_cnt1), .wr_served_cnt(wr_cnt1),
    .overflow(ovf1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [511:0] obs,
                     input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic rd_req(input logic [41:0] a, input logic [15:0] m);
    bus0.c0tx_valid = 1'b1;
    bus0.c0tx_addr  = a;
    bus0.c0tx_mdata = m;
    tick();
    bus0.c0tx_valid = 1'b0;
  endtask

  task automatic wr_req(input logic [41:0] a, input logic [511:0] d,
                        input logic [15:0] m);
    bus0.c1tx_valid = 1'b1;
    bus0.c1tx_addr  = a;
    bus0.c1tx_data  = d;
    bus0.c1tx_mdata = m;
    tick();
    bus0.c1tx_valid = 1'b0;
  endtask

  // Called right after the accepting edge; response lands 19 edges later.
  task automatic expect_c0(input string tag, input logic [15:0] m,
                           input logic [511:0] d);
    repeat (18) tick();
    chk({tag, "_early"}, 512'(bus0.c0rx_rsp_valid), 512'(0));
    tick();
    chk({tag, "_vld"}, 512'(bus0.c0rx_rsp_valid), 512'(1));
    chk({tag, "_mdata"}, 512'(bus0.c0rx_mdata), 512'(m));
    chk({tag, "_data"}, bus0.c0rx_data, d);
  endtask

  initial begin
    int          pulses;
    int          nrsp;
    logic [15:0] last_m;

    reset = 1'b1;
    bus0.c0tx_valid = 0; bus0.c0tx_addr = 0; bus0.c0tx_mdata = 0;
    bus0.c1tx_valid = 0; bus0.c1tx_addr = 0; bus0.c1tx_mdata = 0;
    bus0.c1tx_data  = 0;
    bus1.c0tx_valid = 0; bus1.c0tx_addr = 0; bus1.c0tx_mdata = 0;
    bus1.c1tx_valid = 0; bus1.c1tx_addr = 0; bus1.c1tx_mdata = 0;
    bus1.c1tx_data  = 0;
    tick();
    tick();
    chk("rst_c0vld", 512'(bus0.c0rx_rsp_valid), 512'(0));
    chk("rst_c1vld", 512'(bus0.c1rx_rsp_valid), 512'(0));
    chk("rst_almf", 512'({bus0.c0tx_almfull, bus0.c1tx_almfull}), 512'(0));
    chk("rst_cnts", 512'({rd_cnt0, wr_cnt0}), 512'(0));
    chk("rst_ovf", 512'(ovf0), 512'(0));
    chk("rst_data", bus0.c0rx_data, 512'(0));
    reset = 1'b0;

    // Single write at edge 0, read at edge 30
    wr_req(42'h5, DAT_A, 16'h11);
    repeat (18) tick();
    chk("wr1_early", 512'(bus0.c1rx_rsp_valid), 512'(0));
    tick();
    chk("wr1_vld", 512'(bus0.c1rx_rsp_valid), 512'(1));
    chk("wr1_mdata", 512'(bus0.c1rx_mdata), 512'(16'h11));
    chk("wr1_cnt", 512'(wr_cnt0), 512'(1));
    tick();
    chk("wr1_pulse", 512'(bus0.c1rx_rsp_valid), 512'(0));
    repeat (9) tick();
    rd_req(42'h5, 16'h12);
    expect_c0("rd1", 16'h12, DAT_A);
    chk("rd1_cnts", 512'({rd_cnt0, wr_cnt0}), 512'({16'd1, 16'd1}));
    tick();
    chk("rd1_pulse", 512'(bus0.c0rx_rsp_valid), 512'(0));

    rd_req(42'h3F, 16'h22);
    expect_c0("unwritten", 16'h22, 512'(0));
    rd_req(42'h2_0000_0045, 16'h23);
    expect_c0("alias", 16'h23, DAT_A);

    // Back-to-back fill past capacity
    do_reset();
    for (int i = 0; i <= 8; i++) begin
      bus0.c0tx_valid = 1'b1;
      bus0.c0tx_addr  = 42'(i);
      bus0.c0tx_mdata = 16'(16'h100 + i);
      tick();
      chk($sformatf("fill_almf_%0d", i), 512'(bus0.c0tx_almfull),
          512'(i >= 6));
      chk($sformatf("fill_ovf_%0d", i), 512'(ovf0), 512'(i == 8));
    end
    bus0.c0tx_valid = 1'b0;
    for (int e = 9; e <= 30; e++) begin
      tick();
      chk($sformatf("fill_vld_%0d", e), 512'(bus0.c0rx_rsp_valid),
          512'(e >= 19 && e <= 26));
      if (e >= 19 && e <= 26)
        chk($sformatf("fill_md_%0d", e), 512'(bus0.c0rx_mdata),
            512'(16'h100 + e - 19));
    end
    chk("fill_cnt", 512'(rd_cnt0), 512'(8));
    chk("fill_almf_end", 512'(bus0.c0tx_almfull), 512'(0));
    chk("fill_ovf_sticky", 512'(ovf0), 512'(1));

    // Same-edge read/write of one line
    do_reset();
    chk("haz_ovf_clr", 512'(ovf0), 512'(0));
    wr_req(42'h2, PAT_AA, 16'h31);
    repeat (19) tick();
    chk("haz_pre_wr", 512'(bus0.c1rx_rsp_valid), 512'(1));
    bus0.c1tx_valid = 1'b1;
    bus0.c1tx_addr  = 42'h2;
    bus0.c1tx_data  = PAT_BB;
    bus0.c1tx_mdata = 16'h32;
    bus0.c0tx_valid = 1'b1;
    bus0.c0tx_addr  = 42'h2;
    bus0.c0tx_mdata = 16'h33;
    tick();
    bus0.c1tx_valid = 1'b0;
    bus0.c0tx_valid = 1'b0;
    repeat (19) tick();
    chk("haz_c0vld", 512'(bus0.c0rx_rsp_valid), 512'(1));
    chk("haz_c1vld", 512'(bus0.c1rx_rsp_valid), 512'(1));
    chk("haz_old", bus0.c0rx_data, PAT_AA);
    rd_req(42'h2, 16'h34);
    expect_c0("haz_new", 16'h34, PAT_BB);

    // Reset while requests are in flight
    do_reset();
    for (int i = 0; i < 4; i++) rd_req(42'(i), 16'(i));
    repeat (6) tick();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    pulses = 0;
    repeat (60) begin
      tick();
      if (bus0.c0rx_rsp_valid) pulses++;
    end
    chk("mid_rst_pulses", 512'(pulses), 512'(0));
    chk("mid_rst_cnts", 512'({rd_cnt0, wr_cnt0}), 512'(0));
    chk("mid_rst_almf", 512'(bus0.c0tx_almfull), 512'(0));

    // 65536 back-to-back writes at latency 2
    nrsp = 0;
    last_m = '0;
    for (int i = 0; i < 65536; i++) begin
      bus1.c1tx_valid = 1'b1;
      bus1.c1tx_addr  = 42'(i);
      bus1.c1tx_mdata = 16'(i);
      tick();
      if (bus1.c1rx_rsp_valid) begin
        nrsp++;
        last_m = bus1.c1rx_mdata;
      end
      if (i == 65535)
        chk("wrap_ffff", 512'(wr_cnt1), 512'(16'hFFFF));
    end
    bus1.c1tx_valid = 1'b0;
    tick();
    if (bus1.c1rx_rsp_valid) begin
      nrsp++;
      last_m = bus1.c1rx_mdata;
    end
    chk("wrap_nrsp", 512'(nrsp), 512'(65536));
    chk("wrap_cnt0", 512'(wr_cnt1), 512'(0));
    chk("wrap_last_md", 512'(last_m), 512'(16'hFFFF));
    chk("wrap_ovf", 512'(ovf1), 512'(0));
    chk("wrap_almf", 512'(bus1.c1tx_almfull), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
